// File: rtl/aes_pkg.sv
// Shared AES-128 types and constants for the key-preparation engine.
// Holds the byte/word containers, the round-constant table and the FSM state type.
package aes_pkg;

    typedef logic [15:0][7:0] aes_block_t;
    typedef logic [3:0][7:0]  aes_word_t;

    localparam int AES_ROUNDS = 10;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } kp_state_e;

    // Out-of-table round numbers yield zero so a stray counter never injects a constant.
    function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        if ((rnd >= 4'd1) && (rnd <= 4'd10)) begin
            rc = RCON[rnd];
        end else begin
            rc = 8'h00;
        end
        return rc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in and one byte out.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] sub_i,
    output logic [7:0] sub_o
);

    localparam logic [0:255][7:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign sub_o = SBOX_TABLE[sub_i];

endmodule

// File: rtl/aes_dec_keyprep.sv
// Iterative AES-128 forward key schedule: walks one round per clock from the cipher
// key to the round-10 key, which seeds the inverse key expansion of the decrypt path.
module aes_dec_keyprep
    import aes_pkg::*;
#(
    parameter int ROUNDS = AES_ROUNDS,
    parameter int RCW    = 4
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0][7:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    output logic [15:0][7:0] dec_key,
    output logic             dec_key_valid,
    input  logic             dec_key_ready,
    output logic             busy
);

    localparam logic [RCW-1:0] LAST_ROUND = RCW'(ROUNDS);

    kp_state_e      state_q, state_d;
    logic [RCW-1:0] round_q, round_d;
    aes_block_t     key_q, key_d;
    aes_block_t     dec_key_q, dec_key_d;
    logic           key_ready_q, busy_q, dec_key_valid_q;

    aes_word_t  w0_s, w1_s, w2_s, w3_s;
    aes_word_t  rot_s, sub_s, t_s;
    aes_word_t  n0_s, n1_s, n2_s, n3_s;
    aes_block_t next_key_s;

    assign w0_s  = key_q[15:12];
    assign w1_s  = key_q[11:8];
    assign w2_s  = key_q[7:4];
    assign w3_s  = key_q[3:0];
    assign rot_s = {w3_s[2], w3_s[1], w3_s[0], w3_s[3]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .sub_i (rot_s[g]),
            .sub_o (sub_s[g])
        );
    end

    // Rcon lands on the leading byte of the word, i.e. AES byte 0 of the lane.
    assign t_s  = sub_s ^ {aes_rcon(round_q[3:0]), 8'h00, 8'h00, 8'h00};
    assign n0_s = w0_s ^ t_s;
    assign n1_s = w1_s ^ n0_s;
    assign n2_s = w2_s ^ n1_s;
    assign n3_s = w3_s ^ n2_s;
    assign next_key_s = {n0_s, n1_s, n2_s, n3_s};

    // Next-state and datapath update for the IDLE/EXPAND/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        key_d     = key_q;
        dec_key_d = dec_key_q;
        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    key_d   = key_in;
                    round_d = RCW'(1);
                    state_d = ST_EXPAND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXPAND: begin
                key_d   = next_key_s;
                round_d = round_q + RCW'(1);
                if (round_q == LAST_ROUND) begin
                    dec_key_d = next_key_s;
                    state_d   = ST_DONE;
                end else begin
                    state_d   = ST_EXPAND;
                end
            end
            ST_DONE: begin
                if (dec_key_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, key and output registers; status flags are decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            round_q         <= '0;
            key_q           <= '0;
            dec_key_q       <= '0;
            key_ready_q     <= 1'b1;
            busy_q          <= 1'b0;
            dec_key_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            round_q         <= round_d;
            key_q           <= key_d;
            dec_key_q       <= dec_key_d;
            key_ready_q     <= (state_d == ST_IDLE);
            busy_q          <= (state_d == ST_EXPAND);
            dec_key_valid_q <= (state_d == ST_DONE);
        end
    end

    assign key_ready     = key_ready_q;
    assign busy          = busy_q;
    assign dec_key_valid = dec_key_valid_q;
    assign dec_key       = dec_key_q;

endmodule

// File: tb/tb_aes_dec_keyprep.sv
// Self-checking bench for aes_dec_keyprep against a whole-key behavioural model
// built from GF(2^8) arithmetic and the textbook word-array key expansion.
module tb_aes_dec_keyprep;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R2 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] dec_key;
    logic         dec_key_valid;
    logic         dec_key_ready;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_dec_keyprep dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_in        (key_in),
        .key_valid     (key_valid),
        .key_ready     (key_ready),
        .dec_key       (dec_key),
        .dec_key_valid (dec_key_valid),
        .dec_key_ready (dec_key_ready),
        .busy          (busy)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[40], w[41], w[42], w[43]};
    endfunction

    int           m_left;
    logic         m_valid;
    logic [127:0] m_dec;
    logic [127:0] m_pending;
    int           acc_q [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  <= 0;
            m_valid <= 1'b0;
            m_dec   <= '0;
        end else if (m_valid) begin
            if (dec_key_ready) m_valid <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_valid <= 1'b1;
                m_dec   <= m_pending;
            end
        end else if (key_valid) begin
            m_pending <= expand(key_in);
            m_left    <= 10;
            acc_q.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("key_ready", 128'(key_ready), 128'((m_left == 0) && !m_valid));
            chk("busy", 128'(busy), 128'(m_left > 0));
            chk("dec_key_valid", 128'(dec_key_valid), 128'(m_valid));
            chk("dec_key", dec_key, m_dec);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input logic [127:0] k);
        @(negedge clk);
        key_in    = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key_in    = rnd128();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 30) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (dec_key_valid) break;
        end
        if (!dec_key_valid) chk("valid_timeout", 128'(dec_key_valid), 128'(1));
    endtask

    initial begin
        int n;
        int busy_n;
        int sz;
        logic [127:0] exp_k;
        logic [127:0] rk;
        logic [127:0] got_q [$];

        rst_n = 1'b0; key_valid = 1'b0; dec_key_ready = 1'b1; key_in = '0;
        build_sbox();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_key_ready", 128'(key_ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_valid", 128'(dec_key_valid), 128'(0));
        chk("rst_dec_key", dec_key, 128'h0);
        rst_n = 1'b1;

        chk("model_sbox_00", 128'(sbox_m[0]), 128'h63);
        chk("model_sbox_53", 128'(sbox_m[8'h53]), 128'hed);
        chk("model_K1", expand(K1), R1);
        chk("model_K2", expand(K2), R2);

        // FIPS App.A key, latency and one-cycle valid
        send(K1);
        wait_valid(n);
        chk("latency_K1", 128'(n), 128'(10));
        chk("result_K1", dec_key, R1);
        @(negedge clk);
        chk("valid_one_cycle", 128'(dec_key_valid), 128'(0));

        // FIPS C.1 key, busy width
        send(K2);
        busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_n++;
            @(negedge clk);
        end
        chk("busy_cycles", 128'(busy_n), 128'(10));
        chk("result_K2", dec_key, R2);

        // backpressure
        dec_key_ready = 1'b0;
        rk = rnd128();
        exp_k = expand(rk);
        send(rk);
        wait_valid(n);
        sz = acc_q.size();
        for (int i = 0; i < 5; i++) begin
            key_valid = 1'b1;
            key_in    = rnd128();
            @(negedge clk);
            chk("bp_key_ready", 128'(key_ready), 128'(0));
            chk("bp_dec_key", dec_key, exp_k);
            chk("bp_valid", 128'(dec_key_valid), 128'(1));
        end
        key_valid = 1'b0;
        dec_key_ready = 1'b1;
        @(negedge clk);
        chk("bp_ignored", 128'(acc_q.size()), 128'(sz));
        chk("bp_released_ready", 128'(key_ready), 128'(1));
        chk("bp_released_valid", 128'(dec_key_valid), 128'(0));

        // input toggled during expansion
        send(K1);
        repeat (3) @(negedge clk);
        key_in = '1;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        wait_valid(n);
        chk("toggle_result", dec_key, R1);

        // asynchronous reset mid-expansion
        @(negedge clk);
        send(K2);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_dec_key", dec_key, 128'h0);
        chk("abort_valid", 128'(dec_key_valid), 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_key_ready", 128'(key_ready), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;
        send(K1);
        wait_valid(n);
        chk("post_reset_latency", 128'(n), 128'(10));
        chk("post_reset_result", dec_key, R1);

        // back-to-back with key_valid held high
        @(negedge clk);
        @(negedge clk);
        sz = acc_q.size();
        key_in = K1;
        key_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (dec_key_valid) got_q.push_back(dec_key);
            if (acc_q.size() >= sz + 1) key_in = K2;
            if (acc_q.size() >= sz + 2) key_valid = 1'b0;
        end
        key_valid = 1'b0;
        chk("b2b_accepts", 128'(acc_q.size() - sz), 128'(2));
        if (acc_q.size() >= sz + 2)
            chk("b2b_spacing", 128'(acc_q[sz+1] - acc_q[sz]), 128'(12));
        chk("b2b_outputs", 128'(got_q.size()), 128'(2));
        if (got_q.size() >= 2) begin
            chk("b2b_first", got_q[0], R1);
            chk("b2b_second", got_q[1], R2);
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            key_valid     = 1'($urandom_range(0, 1));
            key_in        = rnd128();
            dec_key_ready = ($urandom_range(0, 3) != 0);
        end
        key_valid = 1'b0;
        dec_key_ready = 1'b1;
        repeat (30) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_dec_keyprep.md
Name: aes_dec_keyprep

Overview:
- Iterative AES-128 forward key-schedule engine that sits directly upstream of the decrypt datapath.
- Takes the cipher key and walks the forward expansion one round per clock, ending at the round-10 key.
- The decrypt datapath consumes that round-10 key as its starting key for inverse key expansion.
- Valid/ready handshake on both the input and output sides; single key in flight.

Parameters:
- ROUNDS, 10, number of forward expansion rounds; fixed at 10 for AES-128, other values unsupported.
- RCW, 4, width of round counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_in  in  [15:0][7:0]  cipher key; key_in[15] is AES byte 0 (FIPS order), key_in[0] is byte 15.
- key_valid  in  1  key_in is valid.
- key_ready  out  1  block can accept a key (IDLE only).
- dec_key  out  [15:0][7:0]  round-10 key, same byte order as key_in.
- dec_key_valid  out  1  dec_key holds a finished round-10 key.
- dec_key_ready  in  1  downstream takes dec_key.
- busy  out  1  high in EXPAND.

Behaviour:
- States: IDLE, EXPAND, DONE. Encoding is an implementation choice.
- Reset values (async assert, sync release): state=IDLE, round counter=0, key register=0, dec_key=0, dec_key_valid=0, busy=0, key_ready=1.
- IDLE:
  - key_ready=1.
  - On a rising edge with key_valid=1: load key_in into the key register, counter=1, go to EXPAND.
- EXPAND:
  - key_ready=0, busy=1.
  - Each edge replaces the key register with the next round key and increments the counter.
  - When the edge computes round ROUNDS, go to DONE.
  - Inputs are ignored in this state.
- Round function, words w0..w3 with w0 = bytes 15..12:
  - t = SubWord(RotWord(w3)) ^ {rcon,8'h00,8'h00,8'h00}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - All XOR, no carries; 8-bit byte lanes.
- Rcon, indexed by counter 1..10: 01,02,04,08,10,20,40,80,1b,36. Driven from a constant table, not an xtime chain.
- Latency: key accepted on edge E0; dec_key_valid=1 after edge E10 (10 cycles).
- DONE:
  - dec_key_valid=1, busy=0, key_ready=0.
  - dec_key holds stable until a handshake edge with dec_key_ready=1; then go to IDLE and drop dec_key_valid.
  - dec_key keeps its last value after the handshake.
- No same-cycle chaining: a new key_valid is accepted at the earliest one cycle after the output handshake, because key_ready=1 only in IDLE.
- dec_key_ready held high permanently: DONE lasts exactly one cycle, so throughput is 1 key per 12 cycles.
- key_valid held high continuously: a key is accepted whenever IDLE; the value sampled is whatever key_in holds at that edge.
- Reset mid-EXPAND or in DONE: immediate abort; all outputs go to their reset values; no partial key is ever presented.
- dec_key_valid never asserts without a completed 10-round expansion.

Decomposition:
- Shared package aes_pkg holds:
  - typedef aes_block_t = logic [15:0][7:0];
  - typedef aes_word_t = logic [3:0][7:0];
  - the RCON[1:10] constant table;
  - the AES_ROUNDS=10 constant.
- One sub-module: aes_sbox, a combinational forward S-box (8-bit in/out). Instantiate 4 copies for SubWord.
- The FSM, counter and round XORs stay in aes_dec_keyprep.

Test Plan:
- FIPS-197 App.A key 2b7e151628aed2a6abf7158809cf4f3c, dec_key_ready=1 -> dec_key = d014f9a8c9ee2589e13f0cc8b6630ca6, dec_key_valid exactly 10 cycles after the accept edge, for 1 cycle.
- FIPS-197 C.1 key 000102030405060708090a0b0c0d0e0f -> dec_key = 13111d7fe3944a17f307a78b4d2b30c5; busy high for exactly 10 cycles.
- Backpressure: dec_key_ready=0 for 5 cycles after valid -> dec_key and valid stay stable, key_ready=0, a new key_valid is ignored; raise ready -> handshake, then IDLE with key_ready=1 next cycle.
- Input toggled during EXPAND: drive key_in=ffff...ff with key_valid=1 on cycle 4 -> output is still the original key's round-10 value.
- Reset mid-operation: assert rst_n=0 asynchronously at cycle 6 of EXPAND -> all outputs are 0 and key_ready=1 immediately; the next key produces the correct result with normal latency.
- Back-to-back: key_valid held high with the two FIPS keys, dec_key_ready=1 -> both correct results, accept edges 12 cycles apart.
